// File: rtl/ascon_aead128_seq_if.sv
// ascon_aead128_seq_if
//   Stream-side bundle of the ASCON AEAD-128 sequencer.
//   cmd_*  : one command per message (mode, no-AD flag, key, nonce, expected tag)
//   ad_*   : associated-data block stream (valid/ready, last marker)
//   din_*  : plaintext/ciphertext input block stream (valid/ready, last marker)
//   dout_* : processed output block stream (valid/ready)
//   res_*  : final result (tag, authentication flag, watchdog error)
//   ad_cnt, db_cnt : blocks accepted in the current/last message
//   master : traffic source/sink side; slave : sequencer side.
interface ascon_aead128_seq_if #(
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_mode;
  logic               cmd_no_ad;
  logic [BLOCK_W-1:0] cmd_key;
  logic [BLOCK_W-1:0] cmd_nonce;
  logic [BLOCK_W-1:0] cmd_tag;

  logic               ad_valid;
  logic               ad_ready;
  logic [BLOCK_W-1:0] ad_data;
  logic               ad_last;

  logic               din_valid;
  logic               din_ready;
  logic [BLOCK_W-1:0] din_data;
  logic               din_last;

  logic               dout_valid;
  logic               dout_ready;
  logic [BLOCK_W-1:0] dout_data;

  logic               res_valid;
  logic               res_ready;
  logic [BLOCK_W-1:0] res_tag;
  logic               res_auth_ok;
  logic               res_error;

  logic [CNT_W-1:0]   ad_cnt;
  logic [CNT_W-1:0]   db_cnt;

  modport master (
    output cmd_valid, cmd_mode, cmd_no_ad, cmd_key, cmd_nonce, cmd_tag,
    input  cmd_ready,
    output ad_valid, ad_data, ad_last,
    input  ad_ready,
    output din_valid, din_data, din_last,
    input  din_ready,
    input  dout_valid, dout_data,
    output dout_ready,
    input  res_valid, res_tag, res_auth_ok, res_error,
    output res_ready,
    input  ad_cnt, db_cnt
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_no_ad, cmd_key, cmd_nonce, cmd_tag,
    output cmd_ready,
    input  ad_valid, ad_data, ad_last,
    output ad_ready,
    input  din_valid, din_data, din_last,
    output din_ready,
    output dout_valid, dout_data,
    input  dout_ready,
    output res_valid, res_tag, res_auth_ok, res_error,
    input  res_ready,
    output ad_cnt, db_cnt
  );
endinterface

// File: rtl/ascon_aead128_seq.sv
// ascon_aead128_seq
//   Stream-side sequencer for the ascon_aead128 core. Accepts one command,
//   then AD and data blocks, drives the core's init/AD/DB controls, buffers
//   each output block until taken downstream and reports tag + auth flag.
//   A per-phase watchdog aborts to RESULT with res_error if the core stalls.
// Ports
//   aclk, areset    : clock, asynchronous active-high reset
//   bus (slave)     : cmd / ad / din / dout / res streams and block counters
//   core_init       : one-cycle init pulse; core_mode/core_key/core_nonce latched
//   core_ad_valid/core_ad_last, core_db_valid/core_db_last : block pulses
//   core_blk        : block accompanying core_ad_valid / core_db_valid
//   core_ready      : core idle and able to take the next init/block
//   core_dout_valid/core_dout : processed block pulse from the core
//   core_tag_valid/core_tag   : final tag pulse from the core
// BLOCK_W is fixed at 128 by the core.
module ascon_aead128_seq #(
  parameter int BLOCK_W  = 128,
  parameter int WDOG_MAX = 1024,
  parameter int CNT_W    = 16
) (
  input  logic               aclk,
  input  logic               areset,
  ascon_aead128_seq_if.slave bus,
  output logic               core_init,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_nonce,
  output logic               core_ad_valid,
  output logic               core_ad_last,
  output logic               core_db_valid,
  output logic               core_db_last,
  output logic [BLOCK_W-1:0] core_blk,
  input  logic               core_ready,
  input  logic               core_dout_valid,
  input  logic [BLOCK_W-1:0] core_dout,
  input  logic               core_tag_valid,
  input  logic [BLOCK_W-1:0] core_tag
);

  localparam int WD_W = $clog2(WDOG_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD,
    S_DB,
    S_DBOUT,
    S_TAG,
    S_RESULT
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               no_ad_q, no_ad_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] nonce_q, nonce_d;
  logic [BLOCK_W-1:0] exp_tag_q, exp_tag_d;
  logic [CNT_W-1:0]   ad_cnt_q, ad_cnt_d;
  logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic               last_q, last_d;
  logic [BLOCK_W-1:0] dout_data_q, dout_data_d;
  logic               dout_valid_q, dout_valid_d;
  logic [BLOCK_W-1:0] res_tag_q, res_tag_d;
  logic               res_auth_q, res_auth_d;
  logic               res_err_q, res_err_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               wait_core;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      no_ad_q      <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      exp_tag_q    <= '0;
      ad_cnt_q     <= '0;
      db_cnt_q     <= '0;
      last_q       <= 1'b0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      res_tag_q    <= '0;
      res_auth_q   <= 1'b0;
      res_err_q    <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      no_ad_q      <= no_ad_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      exp_tag_q    <= exp_tag_d;
      ad_cnt_q     <= ad_cnt_d;
      db_cnt_q     <= db_cnt_d;
      last_q       <= last_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      res_tag_q    <= res_tag_d;
      res_auth_q   <= res_auth_d;
      res_err_q    <= res_err_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    no_ad_d       = no_ad_q;
    key_d         = key_q;
    nonce_d       = nonce_q;
    exp_tag_d     = exp_tag_q;
    ad_cnt_d      = ad_cnt_q;
    db_cnt_d      = db_cnt_q;
    last_d        = last_q;
    dout_data_d   = dout_data_q;
    dout_valid_d  = dout_valid_q;
    res_tag_d     = res_tag_q;
    res_auth_d    = res_auth_q;
    res_err_d     = res_err_q;
    wait_core     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.ad_ready  = 1'b0;
    bus.din_ready = 1'b0;
    core_init     = 1'b0;
    core_ad_valid = 1'b0;
    core_ad_last  = 1'b0;
    core_db_valid = 1'b0;
    core_db_last  = 1'b0;
    core_blk      = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          mode_d     = bus.cmd_mode;
          no_ad_d    = bus.cmd_no_ad;
          key_d      = bus.cmd_key;
          nonce_d    = bus.cmd_nonce;
          exp_tag_d  = bus.cmd_tag;
          ad_cnt_d   = '0;
          db_cnt_d   = '0;
          res_tag_d  = '0;
          res_auth_d = 1'b0;
          res_err_d  = 1'b0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        if (core_ready) begin
          core_init = 1'b1;
          state_d   = no_ad_q ? S_DB : S_AD;
        end else begin
          wait_core = 1'b1;
        end
      end
      S_AD: begin
        bus.ad_ready = core_ready;
        if (!core_ready) begin
          wait_core = 1'b1;
        end else if (bus.ad_valid) begin
          core_ad_valid = 1'b1;
          core_ad_last  = bus.ad_last;
          core_blk      = bus.ad_data;
          ad_cnt_d      = (ad_cnt_q == '1) ? ad_cnt_q : ad_cnt_q + CNT_W'(1);
          if (bus.ad_last) state_d = S_DB;
        end
      end
      S_DB: begin
        bus.din_ready = core_ready;
        if (!core_ready) begin
          wait_core = 1'b1;
        end else if (bus.din_valid) begin
          core_db_valid = 1'b1;
          core_db_last  = bus.din_last;
          core_blk      = bus.din_data;
          db_cnt_d      = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + CNT_W'(1);
          last_d        = bus.din_last;
          state_d       = S_DBOUT;
        end
      end
      S_DBOUT: begin
        // Holding a block for downstream is not a core wait, so the watchdog
        // only runs before the core has delivered the block.
        if (dout_valid_q) begin
          if (bus.dout_ready) begin
            dout_valid_d = 1'b0;
            state_d      = last_q ? S_TAG : S_DB;
          end
        end else if (core_dout_valid) begin
          dout_data_d  = core_dout;
          dout_valid_d = 1'b1;
        end else begin
          wait_core = 1'b1;
        end
      end
      S_TAG: begin
        if (core_tag_valid) begin
          res_tag_d  = core_tag;
          res_auth_d = mode_q ? (core_tag == exp_tag_q) : 1'b1;
          state_d    = S_RESULT;
        end else begin
          wait_core = 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wait_core && (wdog_q == WD_W'(WDOG_MAX - 1))) begin
      state_d    = S_RESULT;
      res_err_d  = 1'b1;
      res_auth_d = 1'b0;
      res_tag_d  = '0;
    end

    if (state_d != state_q)  wdog_d = '0;
    else if (wait_core)      wdog_d = wdog_q + WD_W'(1);
    else                     wdog_d = wdog_q;
  end

  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_data   = dout_data_q;
  assign bus.res_valid   = (state_q == S_RESULT);
  assign bus.res_tag     = res_tag_q;
  assign bus.res_auth_ok = res_auth_q;
  assign bus.res_error   = res_err_q;
  assign bus.ad_cnt      = ad_cnt_q;
  assign bus.db_cnt      = db_cnt_q;
  assign core_mode       = mode_q;
  assign core_key        = key_q;
  assign core_nonce      = nonce_q;

endmodule

// File: tb/tb_ascon_aead128_seq.sv
// tb_ascon_aead128_seq
//   Drives the sequencer through its streams against a cycle-level stub core
//   that implements a small duplex-style toy AEAD. Expected outputs come from
//   a whole-message reference function over block arrays.
module tb_ascon_aead128_seq;
  localparam int BW = 128;
  localparam int CW = 16;
  localparam int WD = 40;

  typedef logic [BW-1:0] blk_t;
  typedef blk_t blk_arr_t [4];

  typedef struct {
    logic           mode;
    logic           no_ad;
    int             n_ad;
    int             n_db;
    logic [CW-1:0]  exp_ad_cnt;
    logic [CW-1:0]  exp_db_cnt;
    logic           exp_auth;
  } vec_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  ascon_aead128_seq_if #(.BLOCK_W(BW), .CNT_W(CW)) bus ();

  logic core_init, core_mode, core_ad_valid, core_ad_last, core_db_valid, core_db_last;
  logic [BW-1:0] core_key, core_nonce, core_blk;
  logic core_ready, core_dout_valid, core_tag_valid;
  logic [BW-1:0] core_dout, core_tag;

  ascon_aead128_seq #(.BLOCK_W(BW), .WDOG_MAX(WD), .CNT_W(CW)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .bus             (bus),
    .core_init       (core_init),
    .core_mode       (core_mode),
    .core_key        (core_key),
    .core_nonce      (core_nonce),
    .core_ad_valid   (core_ad_valid),
    .core_ad_last    (core_ad_last),
    .core_db_valid   (core_db_valid),
    .core_db_last    (core_db_last),
    .core_blk        (core_blk),
    .core_ready      (core_ready),
    .core_dout_valid (core_dout_valid),
    .core_dout       (core_dout),
    .core_tag_valid  (core_tag_valid),
    .core_tag        (core_tag)
  );

  // ---------------- toy cipher ----------------
  function automatic blk_t mix(blk_t x);
    return ({x[122:0], x[127:123]} ^ {x[88:0], x[127:89]} ^ x) + 128'h243F6A8885A308D313198A2E03707344;
  endfunction

  // Whole-message reference: state absorbs AD, each data block is XORed with
  // the state and the ciphertext is absorbed; tag = final state ^ key.
  task automatic model(input logic mode, input blk_t key, input blk_t nonce,
                       input blk_arr_t ad, input int n_ad, input blk_arr_t di, input int n_db,
                       output blk_arr_t dout, output blk_t tag);
    blk_t s;
    s = mix(key ^ nonce);
    for (int i = 0; i < n_ad; i++) s = mix(s ^ ad[i]);
    for (int i = 0; i < 4; i++) dout[i] = '0;
    for (int i = 0; i < n_db; i++) begin
      dout[i] = di[i] ^ s;
      s = mix(mode ? di[i] : dout[i]);
    end
    tag = s ^ key;
  endtask

  // ---------------- stub core ----------------
  blk_t s_q, pend_q, ckey_q, tmp_o;
  logic pend_last_q, cmode_q;
  int   busy, dt, tt;
  logic suppress_tag = 1'b0;
  int   ad_pulses = 0;
  int   cyc = 0;

  assign core_ready = (busy == 0) && (dt == 0) && (tt == 0);

  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) if (core_ad_valid) ad_pulses <= ad_pulses + 1;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_q <= '0; pend_q <= '0; ckey_q <= '0; pend_last_q <= 1'b0; cmode_q <= 1'b0;
      busy <= 0; dt <= 0; tt <= 0;
      core_dout_valid <= 1'b0; core_dout <= '0; core_tag_valid <= 1'b0; core_tag <= '0;
    end else begin
      core_dout_valid <= 1'b0;
      core_tag_valid  <= 1'b0;
      if (busy > 0) busy <= busy - 1;
      if (tt > 0) begin
        tt <= tt - 1;
        if (tt == 1 && !suppress_tag) begin
          core_tag_valid <= 1'b1;
          core_tag       <= s_q ^ ckey_q;
        end
      end
      if (dt > 0) begin
        dt <= dt - 1;
        if (dt == 1) begin
          core_dout_valid <= 1'b1;
          core_dout       <= pend_q;
          if (pend_last_q) tt <= 4;
        end
      end
      if (core_init) begin
        s_q <= mix(core_key ^ core_nonce); ckey_q <= core_key; cmode_q <= core_mode; busy <= 3;
      end
      if (core_ad_valid) begin
        s_q <= mix(s_q ^ core_blk); busy <= 2;
      end
      if (core_db_valid) begin
        tmp_o = core_blk ^ s_q;
        pend_q <= tmp_o;
        s_q <= mix(cmode_q ? core_blk : tmp_o);
        pend_last_q <= core_db_last;
        dt <= 2; busy <= 2;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tmo(input string where);
    n_chk++;
    $display("FAIL timeout_%s: handshake not seen within bound, required completion", where);
  endtask

  function automatic blk_t rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stream drivers ----------------
  task automatic send_cmd(input logic mode, input logic no_ad, input blk_t key, input blk_t nonce,
                          input blk_t ctag, output bit ok);
    @(negedge aclk);
    bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_no_ad = no_ad;
    bus.cmd_key = key; bus.cmd_nonce = nonce; bus.cmd_tag = ctag;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (ok) begin @(posedge aclk); #1; end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_ad(input blk_t d, input logic last, output bit ok);
    @(negedge aclk);
    bus.ad_valid = 1'b1; bus.ad_data = d; bus.ad_last = last;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.ad_ready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (ok) begin @(posedge aclk); #1; end
    bus.ad_valid = 1'b0;
  endtask

  task automatic send_din(input blk_t d, input logic last, output bit ok);
    @(negedge aclk);
    bus.din_valid = 1'b1; bus.din_data = d; bus.din_last = last;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.din_ready) begin ok = 1'b1; break; end
      @(negedge aclk);
    end
    if (ok) begin @(posedge aclk); #1; end
    bus.din_valid = 1'b0;
  endtask

  task automatic take_dout(input int stall, output blk_t d, output logic hold_ok,
                           output int t_fire, output bit ok);
    ok = 1'b0; hold_ok = 1'b1; d = '0; t_fire = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (bus.dout_valid) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    d = bus.dout_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      if (bus.din_ready !== 1'b0 || core_db_valid !== 1'b0 ||
          bus.dout_valid !== 1'b1 || bus.dout_data !== d) hold_ok = 1'b0;
    end
    bus.dout_ready = 1'b1;
    @(posedge aclk); #1;
    bus.dout_ready = 1'b0;
    t_fire = cyc;
  endtask

  task automatic take_res(output blk_t tag, output logic auth, output logic err,
                          output int t_res, output bit ok);
    ok = 1'b0; tag = '0; auth = 1'b0; err = 1'b0; t_res = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (bus.res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    t_res = cyc;
    tag = bus.res_tag; auth = bus.res_auth_ok; err = bus.res_error;
    bus.res_ready = 1'b1;
    @(posedge aclk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic run_msg(input logic mode, input logic no_ad, input blk_t key, input blk_t nonce,
                         input blk_t ctag, input blk_arr_t ad, input int n_ad,
                         input blk_arr_t di, input int n_db, input int st_mid, input int st_last,
                         output blk_arr_t dout, output blk_t tag, output logic auth,
                         output logic err, output logic hold_ok, output int t_tag, output int t_res);
    bit   ok;
    blk_t d;
    logic h;
    int   tf;
    for (int i = 0; i < 4; i++) dout[i] = '0;
    tag = '0; auth = 1'b0; err = 1'b0; hold_ok = 1'b1; t_tag = 0; t_res = 0;
    send_cmd(mode, no_ad, key, nonce, ctag, ok);
    if (!ok) begin tmo("cmd"); return; end
    if (!no_ad) begin
      for (int i = 0; i < n_ad; i++) begin
        send_ad(ad[i], (i == n_ad - 1), ok);
        if (!ok) begin tmo("ad"); return; end
      end
    end
    for (int i = 0; i < n_db; i++) begin
      send_din(di[i], (i == n_db - 1), ok);
      if (!ok) begin tmo("din"); return; end
      take_dout((i == n_db - 1) ? st_last : st_mid, d, h, tf, ok);
      if (!ok) begin tmo("dout"); return; end
      dout[i] = d;
      if (!h) hold_ok = 1'b0;
      t_tag = tf;
    end
    take_res(tag, auth, err, t_res, ok);
    if (!ok) tmo("res");
  endtask

  // ---------------- test sequence ----------------
  vec_t     tbl [5];
  blk_t     key, nonce, tagv, exp_tag, key0, nonce0, tag0;
  blk_arr_t adv, dv, exp_o, got_o, ad0, pt0, ct0;
  logic     auth, err, hold_ok;
  int       t_tag, t_res, ap0;
  bit       ok;
  string    nm;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_no_ad = 1'b0;
    bus.cmd_key = '0; bus.cmd_nonce = '0; bus.cmd_tag = '0;
    bus.ad_valid = 1'b0; bus.ad_data = '0; bus.ad_last = 1'b0;
    bus.din_valid = 1'b0; bus.din_data = '0; bus.din_last = 1'b0;
    bus.dout_ready = 1'b0; bus.res_ready = 1'b0;

    tbl[0] = '{1'b0, 1'b0, 2, 3, 16'd2, 16'd3, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 0, 1, 16'd0, 16'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1, 4, 16'd1, 16'd4, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 4, 2, 16'd4, 16'd2, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 0, 2, 16'd0, 16'd2, 1'b1};

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_flags", {bus.dout_valid, bus.res_valid, bus.ad_ready, bus.din_ready, core_init,
                      core_ad_valid, core_db_valid, bus.res_auth_ok, bus.res_error}, '0);
    chk("rst_counts", {bus.ad_cnt, bus.db_cnt}, '0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // Table-driven encrypt messages with random key/nonce/blocks.
    for (int v = 0; v < 5; v++) begin
      key = rnd(); nonce = rnd();
      for (int i = 0; i < 4; i++) begin adv[i] = rnd(); dv[i] = rnd(); end
      model(tbl[v].mode, key, nonce, adv, tbl[v].no_ad ? 0 : tbl[v].n_ad, dv, tbl[v].n_db, exp_o, exp_tag);
      ap0 = ad_pulses;
      run_msg(tbl[v].mode, tbl[v].no_ad, key, nonce, '0, adv, tbl[v].n_ad, dv, tbl[v].n_db,
              $urandom_range(0, 3), $urandom_range(0, 2), got_o, tagv, auth, err, hold_ok, t_tag, t_res);
      for (int i = 0; i < tbl[v].n_db; i++) begin
        $sformat(nm, "v%0d_dout%0d", v, i);
        chk(nm, got_o[i], exp_o[i]);
      end
      $sformat(nm, "v%0d_tag", v);    chk(nm, tagv, exp_tag);
      $sformat(nm, "v%0d_auth", v);   chk(nm, auth, tbl[v].exp_auth);
      $sformat(nm, "v%0d_err", v);    chk(nm, err, 1'b0);
      $sformat(nm, "v%0d_ad_cnt", v); chk(nm, bus.ad_cnt, tbl[v].exp_ad_cnt);
      $sformat(nm, "v%0d_db_cnt", v); chk(nm, bus.db_cnt, tbl[v].exp_db_cnt);
      $sformat(nm, "v%0d_ad_pulses", v);
      chk(nm, ad_pulses - ap0, tbl[v].no_ad ? 0 : tbl[v].n_ad);
      if (v == 0) begin
        key0 = key; nonce0 = nonce; tag0 = tagv; ad0 = adv; pt0 = dv; ct0 = got_o;
      end
    end

    // Decrypt the first message with the right tag, then with bit 0 flipped.
    for (int f = 0; f < 2; f++) begin
      run_msg(1'b1, 1'b0, key0, nonce0, tag0 ^ blk_t'(f), ad0, 2, ct0, 3, 0, 0,
              got_o, tagv, auth, err, hold_ok, t_tag, t_res);
      for (int i = 0; i < 3; i++) begin
        $sformat(nm, "dec%0d_pt%0d", f, i);
        chk(nm, got_o[i], pt0[i]);
      end
      $sformat(nm, "dec%0d_auth", f); chk(nm, auth, (f == 0));
      $sformat(nm, "dec%0d_tag", f);  chk(nm, tagv, tag0);
    end

    // Downstream stall of 50 cycles (longer than the watchdog) between blocks.
    key = rnd(); nonce = rnd();
    for (int i = 0; i < 4; i++) begin adv[i] = rnd(); dv[i] = rnd(); end
    model(1'b0, key, nonce, adv, 1, dv, 3, exp_o, exp_tag);
    run_msg(1'b0, 1'b0, key, nonce, '0, adv, 1, dv, 3, 50, 0,
            got_o, tagv, auth, err, hold_ok, t_tag, t_res);
    chk("stall_hold", hold_ok, 1'b1);
    for (int i = 0; i < 3; i++) begin
      $sformat(nm, "stall_dout%0d", i);
      chk(nm, got_o[i], exp_o[i]);
    end
    chk("stall_tag", tagv, exp_tag);
    chk("stall_err", err, 1'b0);

    // Core never returns a tag: watchdog abort exactly WD cycles into TAG.
    suppress_tag = 1'b1;
    run_msg(1'b0, 1'b0, key, nonce, '0, adv, 1, dv, 1, 0, 0,
            got_o, tagv, auth, err, hold_ok, t_tag, t_res);
    suppress_tag = 1'b0;
    chk("wdog_err", err, 1'b1);
    chk("wdog_auth", auth, 1'b0);
    chk("wdog_tag", tagv, '0);
    chk("wdog_latency", t_res - t_tag, WD);
    chk("wdog_cnt_hold", {bus.ad_cnt, bus.db_cnt}, {16'd1, 16'd1});

    // Asynchronous reset while in DB after one block.
    send_cmd(1'b0, 1'b1, key, nonce, '0, ok);
    if (!ok) tmo("rst_cmd");
    send_din(dv[0], 1'b0, ok);
    if (!ok) tmo("rst_din");
    take_dout(0, got_o[0], hold_ok, t_tag, ok);
    if (!ok) tmo("rst_dout");
    @(negedge aclk);
    chk("pre_rst_db_cnt", bus.db_cnt, 16'd1);
    areset = 1'b1;
    #1;
    chk("mid_rst_flags", {bus.dout_valid, bus.res_valid, bus.ad_ready, bus.din_ready, core_init,
                          core_ad_valid, core_db_valid, core_db_last, bus.res_error}, '0);
    chk("mid_rst_counts", {bus.ad_cnt, bus.db_cnt}, '0);
    chk("mid_rst_dout_data", bus.dout_data, '0);
    chk("mid_rst_core_key", core_key, '0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

    key = rnd(); nonce = rnd();
    for (int i = 0; i < 4; i++) begin adv[i] = rnd(); dv[i] = rnd(); end
    model(1'b0, key, nonce, adv, 2, dv, 3, exp_o, exp_tag);
    run_msg(1'b0, 1'b0, key, nonce, '0, adv, 2, dv, 3, 1, 1,
            got_o, tagv, auth, err, hold_ok, t_tag, t_res);
    for (int i = 0; i < 3; i++) begin
      $sformat(nm, "post_rst_dout%0d", i);
      chk(nm, got_o[i], exp_o[i]);
    end
    chk("post_rst_tag", tagv, exp_tag);
    chk("post_rst_auth", auth, 1'b1);
    chk("post_rst_counts", {bus.ad_cnt, bus.db_cnt}, {16'd2, 16'd3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
